// File: rtl/blastit_pkg.sv
// Shared blastit definitions: command framing constants and the command
// parser state type.
package blastit_pkg;

    localparam logic [7:0]  CMD_SOF       = 8'hA5;
    localparam logic [7:0]  RSP_ACK       = 8'h06;
    localparam logic [7:0]  RSP_NAK       = 8'h15;
    localparam int unsigned CMD_FRAME_LEN = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DHI,
        ST_DLO,
        ST_CSUM,
        ST_RESP
    } cmd_state_t;

endpackage

// File: rtl/uart_cmd_parser.sv
// Decodes 5-byte register-write commands from the uart RX FIFO, verifies the
// XOR checksum and answers ACK/NAK. Optional inter-byte timeout: UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
    import blastit_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int NUM_REGS    = 12,
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [15:0]       reg_wdata,
    output logic [7:0]        err_cnt
);

    cmd_state_t state, state_nxt;
    logic [7:0] addr_q, dhi_q, dlo_q, csum_q, rsp_q;
    logic       frame_ok;
    logic       tmo_hit;
    logic       in_frame;

    assign in_frame = (state == ST_ADDR) || (state == ST_DHI) ||
                      (state == ST_DLO)  || (state == ST_CSUM);

    // csum_q already holds ADDR ^ DHI ^ DLO when the checksum byte is at the head
    assign frame_ok = (r_data == csum_q) &&
                      ((addr_q >> ADDR_W) == 8'd0) &&
                      ({24'd0, addr_q} < 32'(NUM_REGS));

    assign w_data = rsp_q;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (rd_uart || !in_frame) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = in_frame && rx_empty && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_uart   = 1'b0;
        wr_uart   = 1'b0;
        case (state)
            ST_IDLE: begin
                rd_uart = ~rx_empty;
                if (rd_uart && (r_data == CMD_SOF)) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                rd_uart = ~rx_empty;
                if (rd_uart)      state_nxt = ST_DHI;
                else if (tmo_hit) state_nxt = ST_IDLE;
            end
            ST_DHI: begin
                rd_uart = ~rx_empty;
                if (rd_uart)      state_nxt = ST_DLO;
                else if (tmo_hit) state_nxt = ST_IDLE;
            end
            ST_DLO: begin
                rd_uart = ~rx_empty;
                if (rd_uart)      state_nxt = ST_CSUM;
                else if (tmo_hit) state_nxt = ST_IDLE;
            end
            ST_CSUM: begin
                rd_uart = ~rx_empty;
                if (rd_uart)      state_nxt = ST_RESP;
                else if (tmo_hit) state_nxt = ST_IDLE;
            end
            ST_RESP: begin
                wr_uart = ~tx_full;
                if (wr_uart) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) begin
            rd_uart = 1'b0;
            wr_uart = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            dhi_q     <= '0;
            dlo_q     <= '0;
            csum_q    <= '0;
            rsp_q     <= '0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err_cnt   <= '0;
        end else begin
            reg_we <= 1'b0;
            if (rd_uart) begin
                case (state)
                    ST_ADDR: begin
                        addr_q <= r_data;
                        csum_q <= r_data;
                    end
                    ST_DHI: begin
                        dhi_q  <= r_data;
                        csum_q <= csum_q ^ r_data;
                    end
                    ST_DLO: begin
                        dlo_q  <= r_data;
                        csum_q <= csum_q ^ r_data;
                    end
                    ST_CSUM: begin
                        if (frame_ok) begin
                            reg_we    <= 1'b1;
                            reg_addr  <= addr_q[ADDR_W-1:0];
                            reg_wdata <= {dhi_q, dlo_q};
                            rsp_q     <= RSP_ACK;
                        end else begin
                            rsp_q <= RSP_NAK;
                            if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (tmo_hit && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed and random byte streams
// against a frame-level reference model.
module tb_uart_cmd_parser;
    import blastit_pkg::*;

    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_empty = 1'b1;
    logic [7:0]        r_data = 8'h00;
    logic              rd_uart;
    logic              tx_full = 1'b0;
    logic [7:0]        w_data;
    logic              wr_uart;
    logic              reg_we;
    logic [ADDR_W-1:0] reg_addr;
    logic [15:0]       reg_wdata;
    logic [7:0]        err_cnt;

    uart_cmd_parser #(
        .ADDR_W     (ADDR_W),
        .NUM_REGS   (NUM_REGS),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .rd_uart  (rd_uart),
        .tx_full  (tx_full),
        .w_data   (w_data),
        .wr_uart  (wr_uart),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // RX FIFO model (first-word fall-through) and back-pressure source
    logic [7:0]  pendq[$];
    logic [7:0]  rxq[$];
    logic        do_pop;
    logic        tx_hold = 1'b0;
    logic        rand_bp = 1'b0;

    // Reference model state
    logic [7:0]  m_buf[$];
    logic [19:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          m_err = 0;
    logic [3:0]  m_addr = '0;
    logic [15:0] m_data = '0;
    int          n_wr = 0;
    int          n_tx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] a, hi, lo, cs;
        if (m_buf.size() == 0 && b != 8'hA5) return;
        m_buf.push_back(b);
        if (m_buf.size() == CMD_FRAME_LEN) begin
            a  = m_buf[1];
            hi = m_buf[2];
            lo = m_buf[3];
            cs = m_buf[4];
            if (((a ^ hi ^ lo) == cs) && (int'(a) < NUM_REGS)) begin
                m_addr = a[3:0];
                m_data = {hi, lo};
                exp_wr.push_back({m_addr, m_data});
                exp_tx.push_back(8'h06);
            end else begin
                exp_tx.push_back(8'h15);
                if (m_err < 255) m_err++;
            end
            m_buf.delete();
        end
    endtask

    task automatic push(input logic [7:0] b);
        pendq.push_back(b);
        model_byte(b);
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] hi,
                              input logic [7:0] lo, input logic [7:0] cs);
        push(8'hA5); push(a); push(hi); push(lo); push(cs);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((pendq.size() != 0 || rxq.size() != 0 || exp_tx.size() != 0 ||
                exp_wr.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(n < budget), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_err"},   32'(err_cnt),   32'(m_err));
        check({tag, "_addr"},  32'(reg_addr),  32'(m_addr));
        check({tag, "_wdata"}, 32'(reg_wdata), 32'(m_data));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"},    32'(rd_uart),   32'd0);
        check({tag, "_wr"},    32'(wr_uart),   32'd0);
        check({tag, "_we"},    32'(reg_we),    32'd0);
        check({tag, "_wdat"},  32'(w_data),    32'd0);
        check({tag, "_addr"},  32'(reg_addr),  32'd0);
        check({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
        check({tag, "_err"},   32'(err_cnt),   32'd0);
    endtask

    // DUT inputs change only 1 ns after the rising edge
    always @(posedge clk) begin
        do_pop = rd_uart;
        #1;
        if (do_pop && rxq.size() > 0) void'(rxq.pop_front());
        while (pendq.size() > 0) rxq.push_back(pendq.pop_front());
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
        tx_full  = rand_bp ? ($urandom_range(0, 3) == 0) : tx_hold;
    end

    always @(negedge clk) begin
        logic [19:0] ew;
        logic [7:0]  et;
        if (!reset) begin
            if (reg_we) begin
                n_wr++;
                check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", 32'(reg_addr),  32'(ew[19:16]));
                    check("wr_data", 32'(reg_wdata), 32'(ew[15:0]));
                end
            end
            if (wr_uart) begin
                n_tx++;
                check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) begin
                    et = exp_tx.pop_front();
                    check("tx_byte", 32'(w_data), 32'(et));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int first_pop, we_idx, seen, cnt_rd, cnt_wr, wr0, tx0, kind, nn;
    logic [7:0] a, hi, lo, cs, b;

    initial begin
        // Power-up reset
        @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // Good frame, with pop-to-write latency
        push_frame(8'h03, 8'h12, 8'h34, 8'h25);
        first_pop = -1;
        we_idx    = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_uart && first_pop < 0) first_pop = i;
            if (reg_we) begin
                we_idx = i;
                check("good_wr_same_cycle", 32'(wr_uart), 32'd1);
                break;
            end
        end
        check("good_latency", 32'(we_idx - first_pop), 32'd5);
        wait_idle("good", 50);
        check_regs("good");

        // Bad checksum
        push_frame(8'h03, 8'h12, 8'h34, 8'h00);
        wait_idle("badcs", 50);
        check_regs("badcs");

        // Out-of-range then highest valid address
        push_frame(8'h0C, 8'h00, 8'h01, 8'h0D);
        push_frame(8'h0B, 8'h00, 8'h01, 8'h0A);
        wait_idle("range", 80);
        check_regs("range");

        // Noise and back-pressure; a second frame queued behind must wait
        tx_hold = 1'b1;
        wr0 = n_wr;
        push(8'h00); push(8'hFF);
        push_frame(8'h01, 8'hAB, 8'hCD, 8'h67);
        push_frame(8'h02, 8'h00, 8'h07, 8'h05);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            if (reg_we) seen = 1;
        end
        check("bp_write", 32'(seen), 32'd1);
        cnt_rd = 0;
        cnt_wr = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_uart) cnt_rd++;
            if (wr_uart) cnt_wr++;
        end
        check("bp_no_pop", 32'(cnt_rd), 32'd0);
        check("bp_no_tx", 32'(cnt_wr), 32'd0);
        check("bp_queued", 32'(rxq.size()), 32'd5);
        tx_hold = 1'b0;
        wait_idle("bp", 60);
        check("bp_writes", 32'(n_wr - wr0), 32'd2);
        check_regs("bp");

        // Random frames with noise and random back-pressure
        rand_bp = 1'b1;
        for (int f = 0; f < 30; f++) begin
            nn = $urandom_range(0, 3);
            for (int k = 0; k < nn; k++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                push(b);
            end
            kind = $urandom_range(0, 3);
            a  = 8'($urandom_range(0, NUM_REGS - 1));
            hi = 8'($urandom_range(0, 255));
            lo = 8'($urandom_range(0, 255));
            if (kind == 1) a = 8'($urandom_range(NUM_REGS, 255));
            cs = a ^ hi ^ lo;
            if (kind == 2) cs = cs ^ (8'd1 << $urandom_range(0, 7));
            push_frame(a, hi, lo, cs);
        end
        wait_idle("rand", 3000);
        rand_bp = 1'b0;
        @(negedge clk);
        check_regs("rand");

`ifdef UART_CMD_TIMEOUT_EN
        // Stall after the address byte
        tx0 = n_tx;
        push(8'hA5); push(8'h01);
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clk);
            if (rd_uart) seen++;
        end
        check("tmo_pops", 32'(seen), 32'd2);
        repeat (16) @(negedge clk);
        check("tmo_early", 32'(err_cnt), 32'(m_err));
        @(negedge clk);
        m_buf.delete();
        if (m_err < 255) m_err++;
        check("tmo_err", 32'(err_cnt), 32'(m_err));
        repeat (5) @(negedge clk);
        check("tmo_no_tx", 32'(n_tx - tx0), 32'd0);
        push_frame(8'h07, 8'h55, 8'hAA, 8'hF8);
        wait_idle("tmo_after", 50);
        check_regs("tmo_after");
`endif

        // Error counter saturation
        for (int f = 0; f < 260; f++) push_frame(8'h01, 8'h02, 8'h03, 8'hFF);
        wait_idle("sat", 5000);
        check("sat_model", 32'(m_err), 32'd255);
        check_regs("sat");

        // Reset mid-frame
        push(8'hA5); push(8'h01);
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            @(negedge clk);
            if (rd_uart) seen++;
        end
        check("rst_pops", 32'(seen), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        m_buf.delete();
        exp_wr.delete();
        exp_tx.delete();
        m_err  = 0;
        m_addr = '0;
        m_data = '0;
        reset  = 1'b0;
        wr0 = n_wr;
        push_frame(8'h05, 8'hBE, 8'hEF, 8'h54);
        wait_idle("post_rst", 50);
        check("post_rst_writes", 32'(n_wr - wr0), 32'd1);
        check_regs("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
